// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the 32x32 register file: pipeline writeback has priority,
// the auxiliary unit is guaranteed service by a forced pipeline hold after bounded starvation.
module regfile_wr_sched #(
    parameter int MAX_WAIT = 4,
    parameter int DW       = 32,
    parameter int AW       = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_we,
    input  logic [AW-1:0] pipe_waddr,
    input  logic [DW-1:0] pipe_wdata,
    input  logic          aux_valid,
    input  logic [AW-1:0] aux_waddr,
    input  logic [DW-1:0] aux_wdata,
    output logic          aux_ready,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_waddr,
    input  logic [AW-1:0] chk_addr0,
    input  logic [AW-1:0] chk_addr1,
    output logic          chk_busy0,
    output logic          chk_busy1,
    output logic          pipe_hold,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          err
);

    localparam int              NREG      = 2 ** AW;
    localparam int              WCW       = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0]  WAIT_SAT  = WCW'(MAX_WAIT);
    localparam logic [WCW-1:0]  WAIT_TRIG = WCW'(MAX_WAIT - 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [NREG-1:0] sb_q, sb_d;
    logic            pipe_hold_q, pipe_hold_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]   rf_wdata_q, rf_wdata_d;
    logic            err_q, err_d;

    logic preq;
    logic aux_hs;
    logic sb_set;
    logic sb_clr;

    always_comb begin
        preq      = pipe_we && (pipe_waddr != '0);
        aux_ready = (state_q == HOLD) ? 1'b1 : !preq;
        aux_hs    = aux_valid && aux_ready;
        sb_set    = iss_valid && (iss_waddr != '0);
        sb_clr    = aux_hs && (aux_waddr != '0);
    end

    // Port arbitration; the pipe loses only while HOLD is active.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (state_q == IDLE && preq) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pipe_waddr;
            rf_wdata_d = pipe_wdata;
        end else if (sb_clr) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = aux_waddr;
            rf_wdata_d = aux_wdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (!aux_valid || aux_hs) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_SAT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        case (state_q)
            IDLE: if (aux_valid && !aux_ready && wait_cnt_q == WAIT_TRIG) state_d = HOLD;
            HOLD: if (aux_hs || !aux_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        pipe_hold_d = (state_d == HOLD);
    end

    // Clear first, then set, so a same-cycle set of the same bit wins.
    always_comb begin
        sb_d  = sb_q;
        err_d = err_q;
        if (sb_clr) sb_d[aux_waddr] = 1'b0;
        if (sb_set) sb_d[iss_waddr] = 1'b1;
        if (sb_set && sb_q[iss_waddr] && !(sb_clr && aux_waddr == iss_waddr)) err_d = 1'b1;
        if (sb_clr && !sb_q[aux_waddr]) err_d = 1'b1;
        if (state_q == HOLD && preq) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            sb_q        <= '0;
            pipe_hold_q <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            sb_q        <= sb_d;
            pipe_hold_q <= pipe_hold_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        chk_busy0 = sb_q[chk_addr0] && (chk_addr0 != '0);
        chk_busy1 = sb_q[chk_addr1] && (chk_addr1 != '0);
        pipe_hold = pipe_hold_q;
        rf_we     = rf_we_q;
        rf_waddr  = rf_waddr_q;
        rf_wdata  = rf_wdata_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched: expected rf writes are queued by the stimulus
// and popped by a negedge monitor; control outputs are checked inline.
module tb_regfile_wr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        aux_valid;
    logic [4:0]  aux_waddr;
    logic [31:0] aux_wdata;
    logic        aux_ready;
    logic        iss_valid;
    logic [4:0]  iss_waddr;
    logic [4:0]  chk_addr0;
    logic [4:0]  chk_addr1;
    logic        chk_busy0;
    logic        chk_busy1;
    logic        pipe_hold;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        err;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    logic mon_en = 1'b0;

    regfile_wr_sched #(.MAX_WAIT(4), .DW(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .aux_valid(aux_valid), .aux_waddr(aux_waddr), .aux_wdata(aux_wdata),
        .aux_ready(aux_ready),
        .iss_valid(iss_valid), .iss_waddr(iss_waddr),
        .chk_addr0(chk_addr0), .chk_addr1(chk_addr1),
        .chk_busy0(chk_busy0), .chk_busy1(chk_busy1),
        .pipe_hold(pipe_hold),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic idle();
        pipe_we    = 1'b0;
        pipe_waddr = '0;
        pipe_wdata = '0;
        aux_valid  = 1'b0;
        aux_waddr  = '0;
        aux_wdata  = '0;
        iss_valid  = 1'b0;
        iss_waddr  = '0;
    endtask

    // Each committed write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mon_en && rf_we !== 1'b0) begin
            wr_t w;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got we=%b addr=%0d data=%0h expected no write",
                         rf_we, rf_waddr, rf_wdata);
            end else begin
                w = exp_q.pop_front();
                if (rf_we !== 1'b1 || rf_waddr !== w.a || rf_wdata !== w.d) begin
                    errors++;
                    $display("FAIL rf_write: got addr=%0d data=%0h expected addr=%0d data=%0h",
                             rf_waddr, rf_wdata, w.a, w.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        chk_addr0 = '0;
        chk_addr1 = '0;
        rst = 1'b1;
        // Reset with random inputs.
        for (int i = 0; i < 2; i++) begin
            pipe_we    = 1'($urandom);
            pipe_waddr = 5'($urandom);
            pipe_wdata = $urandom;
            aux_valid  = 1'($urandom);
            aux_waddr  = 5'($urandom);
            aux_wdata  = $urandom;
            iss_valid  = 1'($urandom);
            iss_waddr  = 5'($urandom);
            tick();
        end
        idle();
        settle();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_pipe_hold", pipe_hold, 0);
        chk("rst_err", err, 0);
        for (int i = 0; i < 32; i++) begin
            chk_addr0 = 5'(i);
            chk_addr1 = 5'(31 - i);
            settle();
            chk("rst_busy0", chk_busy0, 0);
            chk("rst_busy1", chk_busy1, 0);
        end
        tick();
        rst = 1'b0;
        mon_en = 1'b1;

        // Pipe-only write, then a pipe write to r0.
        tick();
        pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'hDEADBEEF;
        push(5'd5, 32'hDEADBEEF);
        tick();
        idle();
        settle();
        chk("pipe_rf_we", rf_we, 1);
        chk("pipe_rf_waddr", rf_waddr, 5);
        pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'h123;
        settle();
        chk("r0_aux_ready", aux_ready, 1);
        tick();
        idle();
        settle();
        chk("r0_rf_we", rf_we, 0);

        // Reserve r7, then contention between aux r7 and pipe r3.
        iss_valid = 1'b1; iss_waddr = 5'd7;
        tick();
        idle();
        aux_valid = 1'b1; aux_waddr = 5'd7; aux_wdata = 32'h11;
        pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'hA1;
        push(5'd3, 32'hA1);
        settle();
        chk("c0_aux_ready", aux_ready, 0);
        chk("c0_hold", pipe_hold, 0);
        tick();
        pipe_wdata = 32'hA2;
        push(5'd3, 32'hA2);
        settle();
        chk("c1_aux_ready", aux_ready, 0);
        chk("c1_hold", pipe_hold, 0);
        tick();
        pipe_we = 1'b0;
        push(5'd7, 32'h11);
        settle();
        chk("c2_aux_ready", aux_ready, 1);
        chk("c2_hold", pipe_hold, 0);
        tick();
        idle();
        settle();
        chk("c3_hold", pipe_hold, 0);
        chk("c3_rf_waddr", rf_waddr, 7);
        chk("c3_err", err, 0);

        // Scoreboard reserve / release of r9.
        iss_valid = 1'b1; iss_waddr = 5'd9;
        chk_addr0 = 5'd9; chk_addr1 = 5'd9;
        settle();
        chk("sb_no_bypass", chk_busy0, 0);
        tick();
        iss_valid = 1'b0;
        settle();
        chk("sb_busy0", chk_busy0, 1);
        chk("sb_busy1", chk_busy1, 1);
        aux_valid = 1'b1; aux_waddr = 5'd9; aux_wdata = 32'h99;
        push(5'd9, 32'h99);
        settle();
        chk("sb_busy_until_commit", chk_busy0, 1);
        chk("sb_aux_ready", aux_ready, 1);
        tick();
        idle();
        settle();
        chk("sb_cleared", chk_busy0, 0);
        chk("sb_commit_we", rf_we, 1);
        chk("sb_commit_addr", rf_waddr, 9);
        // Same-cycle set and clear of r9 while reserved.
        iss_valid = 1'b1; iss_waddr = 5'd9;
        tick();
        aux_valid = 1'b1; aux_waddr = 5'd9; aux_wdata = 32'h55;
        push(5'd9, 32'h55);
        tick();
        idle();
        settle();
        chk("same_set_wins", chk_busy0, 1);
        chk("same_no_err", err, 0);
        aux_valid = 1'b1; aux_waddr = 5'd9; aux_wdata = 32'h66;
        push(5'd9, 32'h66);
        tick();
        idle();
        settle();
        chk("same_cleared", chk_busy0, 0);
        chk("same_err", err, 0);

        // Starvation: aux r12 refused 4 cycles, accepted in the HOLD cycle.
        iss_valid = 1'b1; iss_waddr = 5'd12;
        tick();
        iss_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pipe_we = 1'b1; pipe_waddr = 5'(k + 1); pipe_wdata = 32'(256 + k);
            aux_valid = 1'b1; aux_waddr = 5'd12; aux_wdata = 32'hC;
            push(5'(k + 1), 32'(256 + k));
            settle();
            chk("starve_aux_ready", aux_ready, 0);
            chk("starve_hold", pipe_hold, 0);
            tick();
        end
        pipe_we = 1'b0;
        push(5'd12, 32'hC);
        settle();
        chk("starve_hold_up", pipe_hold, 1);
        chk("starve_aux_accept", aux_ready, 1);
        tick();
        idle();
        settle();
        chk("starve_hold_down", pipe_hold, 0);
        chk("starve_rf_waddr", rf_waddr, 12);
        chk("starve_rf_wdata", rf_wdata, 32'hC);
        chk("starve_err", err, 0);

        // Double reservation of r4 -> sticky err.
        iss_valid = 1'b1; iss_waddr = 5'd4;
        tick();
        settle();
        chk("dbl_err_first", err, 0);
        tick();
        iss_valid = 1'b0;
        settle();
        chk("dbl_err_set", err, 1);
        tick();
        tick();
        settle();
        chk("dbl_err_sticky", err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_addr0 = 5'd4;
        settle();
        chk("dbl_err_rst", err, 0);
        chk("dbl_busy_rst", chk_busy0, 0);

        // Pipe write during HOLD: err, only aux r13 commits.
        iss_valid = 1'b1; iss_waddr = 5'd13;
        tick();
        iss_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pipe_we = 1'b1; pipe_waddr = 5'(k + 20); pipe_wdata = 32'(512 + k);
            aux_valid = 1'b1; aux_waddr = 5'd13; aux_wdata = 32'hD;
            push(5'(k + 20), 32'(512 + k));
            tick();
        end
        pipe_waddr = 5'd2; pipe_wdata = 32'h22;
        push(5'd13, 32'hD);
        settle();
        chk("hold_err_hold", pipe_hold, 1);
        tick();
        idle();
        settle();
        chk("hold_err_set", err, 1);
        chk("hold_err_addr", rf_waddr, 13);
        tick();
        settle();
        chk("hold_err_pipe_dropped", rf_we, 0);

        // Reset in the middle of a starvation wait.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        iss_valid = 1'b1; iss_waddr = 5'd14;
        tick();
        iss_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pipe_we = 1'b1; pipe_waddr = 5'(k + 24); pipe_wdata = 32'(768 + k);
            aux_valid = 1'b1; aux_waddr = 5'd14; aux_wdata = 32'hE;
            push(5'(k + 24), 32'(768 + k));
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_addr0 = 5'd14;
        settle();
        chk("midrst_rf_we", rf_we, 0);
        chk("midrst_hold", pipe_hold, 0);
        chk("midrst_err", err, 0);
        chk("midrst_busy", chk_busy0, 0);
        for (int k = 0; k < 3; k++) begin
            pipe_we = 1'b1; pipe_waddr = 5'(k + 27); pipe_wdata = 32'(1024 + k);
            push(5'(k + 27), 32'(1024 + k));
            settle();
            chk("midrst_wait_hold", pipe_hold, 0);
            tick();
        end
        idle();
        settle();
        chk("midrst_wait_reset", pipe_hold, 0);

        tick();
        tick();
        settle();
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wr_sched.md
Name: regfile_wr_sched

Overview:
- Scheduler for the single write port of the 32x32 register file.
- Arbitrates between two writers:
  - the in-order pipeline writeback (priority; cannot be back-pressured);
  - a multi-cycle auxiliary unit (divider/load return; valid/ready handshake).
- Keeps a scoreboard of registers reserved by in-flight auxiliary operations so decode can detect RAW hazards.
- Guarantees the auxiliary unit forward progress by forcing a pipeline hold after bounded starvation.

Parameters:
- MAX_WAIT, 4, cycles aux may be refused before a pipeline hold is forced (>=1).
- DW, 32, data width.
- AW, 5, register address width (2**AW registers; register 0 hard-wired zero).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset. Synchronous, active-high.
- pipe_we  in  1  pipeline writeback request.
- pipe_waddr  in  AW  pipeline destination.
- pipe_wdata  in  DW  pipeline data.
- aux_valid  in  1  aux unit has a result.
- aux_waddr  in  AW  aux destination.
- aux_wdata  in  DW  aux data.
- aux_ready  out  1  aux result accepted this cycle (combinational).
- iss_valid  in  1  long-latency op issued; reserve iss_waddr.
- iss_waddr  in  AW  register to reserve.
- chk_addr0  in  AW  decode source address 0.
- chk_addr1  in  AW  decode source address 1.
- chk_busy0  out  1  chk_addr0 is reserved (combinational from scoreboard).
- chk_busy1  out  1  chk_addr1 is reserved (combinational from scoreboard).
- pipe_hold  out  1  pipeline must not write back this cycle (registered).
- rf_we  out  1  register file write enable (registered).
- rf_waddr  out  AW  register file write address (registered).
- rf_wdata  out  DW  register file write data (registered).
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst=1 at clk edge): rf_we=0, rf_waddr=0, rf_wdata=0, pipe_hold=0, err=0, scoreboard all-clear, wait_cnt=0, FSM=IDLE.
- Effective pipe request: preq = pipe_we && pipe_waddr!=0. A pipe write to r0 is not a request.
- FSM IDLE:
  - aux_ready = !preq.
  - preq wins the port.
- FSM HOLD:
  - pipe_hold=1; aux_ready=1; aux wins the port.
  - preq during HOLD is a protocol error: set err; the aux write proceeds; the pipe write is dropped.
- Grant/commit latency is 1 cycle:
  - Winner's addr/data appear on rf_* at the next edge with rf_we=1.
  - No winner -> rf_we=0; rf_waddr/rf_wdata hold their previous values.
- Aux handshake = aux_valid && aux_ready.
  - aux_waddr==0: handshake completes, no rf write, no scoreboard change.
- Scoreboard:
  - Set bit iss_waddr on iss_valid && iss_waddr!=0.
  - Clear bit aux_waddr on aux handshake.
  - Same-cycle set and clear of the same bit: set wins.
  - iss_valid to an already-set bit (not simultaneously cleared): set err, bit stays set.
  - Aux handshake to a clear bit: set err.
- chk_busyN = scoreboard[chk_addrN] && chk_addrN!=0. Pure read of current state; no bypass of same-cycle set/clear.
  - The bit clears at the same edge rf_we commits the data, so the regfile read bypass covers the first non-busy cycle.
- Starvation counter wait_cnt:
  - Increments each cycle aux_valid && !aux_ready.
  - Zeroed on aux handshake or !aux_valid.
  - Saturates at MAX_WAIT.
- IDLE -> HOLD when aux_valid && !aux_ready && wait_cnt==MAX_WAIT-1. pipe_hold rises the following cycle.
- HOLD -> IDLE on aux handshake or !aux_valid. pipe_hold falls the next cycle; wait_cnt=0.
- Maximum aux wait: MAX_WAIT refused cycles, then accepted in the first HOLD cycle.
- err clears only on rst.
- rst asserted mid-HOLD or mid-wait:
  - All state returns to reset values at that edge.
  - Outstanding reservations are discarded; the aux unit is reset by the same rst.

Test Plan:
- Reset check: hold rst 2 cycles with random inputs -> rf_we=0, pipe_hold=0, err=0, chk_busy0/1=0 for every address.
- Pipe-only write: pipe_we=1, waddr=5, wdata=0xDEADBEEF; aux idle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF. Same with waddr=0 -> rf_we stays 0.
- Contention: aux_valid=1 (r7, 0x11) and pipe_we=1 (r3) on cycles 0-1, pipe idle cycle 2:
  - aux_ready=0 on cycles 0-1, =1 on cycle 2;
  - rf commits r3, r3, r7 on cycles 1, 2, 3;
  - pipe_hold never asserts.
- Starvation, MAX_WAIT=4: continuous pipe writes plus aux_valid -> aux refused cycles 0-3, pipe_hold=1 and aux_ready=1 at cycle 4, rf_waddr=aux addr at cycle 5, pipe_hold=0 at cycle 5.
- Scoreboard: iss_valid r9 -> chk_busy0=1 for chk_addr0=9 next cycle; aux handshake r9 -> busy drops the cycle rf_we=1 for r9. Same-cycle iss r9 and aux r9 -> bit stays set, err=0.
- Errors: iss_valid r4 twice without clear -> err=1 and sticky until rst. pipe_we=1 (r2) during HOLD -> err=1, only the aux write commits.
